// File: rtl/sx_bus_pkg.sv
// Shared types and constants for the 386SX bus cycle controller.
// State encoding, special-cycle decodes and fixed read-back data values.
package sx_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_SPEC,
        ST_RDY
    } state_t;

    // {mio, dc, wr} decodes for cycles that never reach the slave
    localparam logic [2:0]  CYC_HALT   = 3'b101;
    localparam logic [2:0]  CYC_INTA   = 3'b000;

    localparam logic [15:0] FLOAT_DATA = 16'hFFFF;
    localparam logic [15:0] INTA_DATA  = 16'h0000;

    function automatic logic is_special(input logic [2:0] cyc);
        return (cyc == CYC_HALT) || (cyc == CYC_INTA);
    endfunction

endpackage

// File: rtl/sx_wait_timer.sv
// Wait-state counter for an outstanding slave request; flags expiry at TIMEOUT.
// Latency: expired is combinational from the count; clr has priority over inc.
module sx_wait_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= 8'd0;
        end else if (clr) begin
            count <= 8'd0;
        end else if (inc) begin
            count <= count + 8'd1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/sx_bus_cycle_ctrl.sv
// 386SX bus cycle controller: decodes ADS# cycles into slave requests and drives READY#.
// Minimum latency ADS# sample -> READY# low is 2 clks; slave stalls are bounded by TIMEOUT.
module sx_bus_cycle_ctrl
    import sx_bus_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ads_n,
    input  logic        mio,
    input  logic        dc,
    input  logic        wr,
    input  logic        lock_n,
    input  logic [1:0]  be_n,
    input  logic [22:0] addr_in,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        data_oe,
    output logic        ready_n,
    output logic        req_valid,
    output logic [22:0] req_addr,
    output logic [1:0]  req_be,
    output logic        req_wr,
    output logic        req_io,
    output logic        req_lock,
    output logic [15:0] req_wdata,
    input  logic        req_ack,
    input  logic [15:0] req_rdata,
    output logic        cycle_active,
    output logic        special_cycle,
    output logic        halt_seen,
    output logic        timeout
);

    state_t     state_q;
    state_t     state_d;
    logic [2:0] cyc_in;
    logic [2:0] cyc_q;
    logic       start;
    logic       start_req;
    logic       count_inc;
    logic       expired;

    assign cyc_in    = {mio, dc, wr};
    assign start_req = start && !is_special(cyc_in);

    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        count_inc = 1'b0;
        case (state_q)
            ST_IDLE, ST_RDY: begin
                state_d = ST_IDLE;
                if (!ads_n) begin
                    start   = 1'b1;
                    state_d = is_special(cyc_in) ? ST_SPEC : ST_REQ;
                end
            end
            ST_REQ: begin
                // ack wins over a simultaneous expiry
                if (req_ack || expired) begin
                    state_d = ST_RDY;
                end else begin
                    count_inc = 1'b1;
                end
            end
            ST_SPEC: state_d = ST_RDY;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cyc_q     <= 3'b000;
            data_out  <= 16'h0000;
            req_addr  <= 23'd0;
            req_be    <= 2'b00;
            req_wr    <= 1'b0;
            req_io    <= 1'b0;
            req_lock  <= 1'b0;
            req_wdata <= 16'h0000;
            halt_seen <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start) begin
                cyc_q <= cyc_in;
                if (cyc_in == CYC_HALT) begin
                    halt_seen <= 1'b1;
                end
            end
            if (start_req) begin
                req_addr  <= addr_in;
                req_be    <= ~be_n;
                req_wr    <= wr;
                req_io    <= ~mio;
                req_lock  <= ~lock_n;
                req_wdata <= data_in;
            end
            if (state_q == ST_REQ) begin
                if (req_ack) begin
                    data_out <= req_rdata;
                end else if (expired) begin
                    data_out <= FLOAT_DATA;
                    timeout  <= 1'b1;
                end
            end
            if ((state_q == ST_SPEC) && (cyc_q == CYC_INTA)) begin
                data_out <= INTA_DATA;
            end
        end
    end

    sx_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (start_req),
        .inc     (count_inc),
        .expired (expired)
    );

    // cyc_q[0] is the captured wr bit: drive the data bus only on reads
    assign req_valid     = (state_q == ST_REQ);
    assign ready_n       = (state_q != ST_RDY);
    assign data_oe       = (state_q == ST_RDY) && !cyc_q[0];
    assign cycle_active  = (state_q != ST_IDLE);
    assign special_cycle = (state_q == ST_SPEC);

endmodule

// File: tb/tb_sx_bus_cycle_ctrl.sv
// Scoreboard bench for sx_bus_cycle_ctrl (TIMEOUT=4) with directed bus cycles.
module tb_sx_bus_cycle_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ads_n = 1'b1;
    logic        mio = 1'b0;
    logic        dc = 1'b0;
    logic        wr = 1'b0;
    logic        lock_n = 1'b1;
    logic [1:0]  be_n = 2'b11;
    logic [22:0] addr_in = 23'd0;
    logic [15:0] data_in = 16'h0000;
    logic [15:0] data_out;
    logic        data_oe;
    logic        ready_n;
    logic        req_valid;
    logic [22:0] req_addr;
    logic [1:0]  req_be;
    logic        req_wr;
    logic        req_io;
    logic        req_lock;
    logic [15:0] req_wdata;
    logic        req_ack = 1'b0;
    logic [15:0] req_rdata = 16'h0000;
    logic        cycle_active;
    logic        special_cycle;
    logic        halt_seen;
    logic        timeout;

    sx_bus_cycle_ctrl #(.TIMEOUT(4)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ads_n         (ads_n),
        .mio           (mio),
        .dc            (dc),
        .wr            (wr),
        .lock_n        (lock_n),
        .be_n          (be_n),
        .addr_in       (addr_in),
        .data_in       (data_in),
        .data_out      (data_out),
        .data_oe       (data_oe),
        .ready_n       (ready_n),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_be        (req_be),
        .req_wr        (req_wr),
        .req_io        (req_io),
        .req_lock      (req_lock),
        .req_wdata     (req_wdata),
        .req_ack       (req_ack),
        .req_rdata     (req_rdata),
        .cycle_active  (cycle_active),
        .special_cycle (special_cycle),
        .halt_seen     (halt_seen),
        .timeout       (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ads_edge;
        int          exp_clk;
        logic [15:0] data;
        logic        chk_data;
        logic        oe;
        logic        tmo;
        logic        halt;
    } rdy_exp_t;

    typedef struct packed {
        logic [22:0] addr;
        logic [1:0]  be;
        logic        wr;
        logic        io;
        logic        lock;
        logic [15:0] wdata;
    } req_exp_t;

    rdy_exp_t rdy_q[$];
    req_exp_t req_q[$];
    int       edge_cnt = 0;
    int       checks = 0;
    int       errors = 0;
    logic     req_prev = 1'b0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drives one ADS# cycle at a negedge; ads_edge is the posedge that samples it.
    task automatic issue(input logic [2:0] cyc, input logic [1:0] be, input logic [22:0] a,
                         input logic [15:0] d, input logic lk, input logic has_req,
                         input req_exp_t rq, input int exp_clk, input logic [15:0] exp_data,
                         input logic chk_data, input logic oe, input logic tmo,
                         input logic hs, output int e);
        rdy_exp_t r;
        {mio, dc, wr} = cyc;
        be_n    = be;
        addr_in = a;
        data_in = d;
        lock_n  = lk;
        ads_n   = 1'b0;
        e = edge_cnt + 1;
        if (has_req) req_q.push_back(rq);
        if (exp_clk > 0) begin
            r.ads_edge = e;
            r.exp_clk  = exp_clk;
            r.data     = exp_data;
            r.chk_data = chk_data;
            r.oe       = oe;
            r.tmo      = tmo;
            r.halt     = hs;
            rdy_q.push_back(r);
        end
        @(negedge clk);
        ads_n = 1'b1;
    endtask

    task automatic ack_at(input int e, input int k, input logic [15:0] rd);
        while (edge_cnt < e + k - 1) @(negedge clk);
        req_ack   = 1'b1;
        req_rdata = rd;
        @(negedge clk);
        req_ack   = 1'b0;
        req_rdata = 16'h0000;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((rdy_q.size() != 0 || cycle_active) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL %s_idle_wait actual=busy required=idle", name);
        end
        @(negedge clk);
    endtask

    // Monitor: READY# completions and request field stability
    always @(negedge clk) begin
        rdy_exp_t x;
        int rel;
        if (reset_n) begin
            if (!ready_n) begin
                checks++;
                if (rdy_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ready actual=ready_n=0 required=ready_n=1");
                end else begin
                    x = rdy_q.pop_front();
                    rel = edge_cnt + 1 - x.ads_edge;
                    if (rel != x.exp_clk || data_oe !== x.oe || timeout !== x.tmo ||
                        halt_seen !== x.halt || (x.chk_data && data_out !== x.data)) begin
                        errors++;
                        $display("FAIL ready_cycle actual clk=%0d data=%h oe=%b tmo=%b halt=%b required clk=%0d data=%h oe=%b tmo=%b halt=%b",
                                 rel, data_out, data_oe, timeout, halt_seen,
                                 x.exp_clk, x.data, x.oe, x.tmo, x.halt);
                    end
                end
            end else begin
                checks++;
                if (data_oe !== 1'b0) begin
                    errors++;
                    $display("FAIL data_oe_outside_rdy actual=%b required=0", data_oe);
                end
            end
        end
        if (req_valid) begin
            checks++;
            if (req_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_req actual=req_valid=1 required=req_valid=0");
            end else if ({req_addr, req_be, req_wr, req_io, req_lock, req_wdata} !== req_q[0]) begin
                errors++;
                $display("FAIL req_fields actual=%h required=%h",
                         {req_addr, req_be, req_wr, req_io, req_lock, req_wdata}, req_q[0]);
            end
            req_prev = 1'b1;
        end else if (req_prev) begin
            if (req_q.size() != 0) void'(req_q.pop_front());
            req_prev = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int e;
        int e2;
        repeat (3) @(negedge clk);
        chk("rst_ready_n", ready_n, 1);
        chk("rst_outputs", {data_oe, req_valid, cycle_active, special_cycle, halt_seen, timeout}, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_req_fields", {req_addr, req_be, req_wr, req_io, req_lock, req_wdata}, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // memory read, ack in first REQ cycle
        issue(3'b110, 2'b00, 23'h7FFFF8, 16'h0000, 1'b1, 1'b1,
              '{23'h7FFFF8, 2'b11, 1'b0, 1'b0, 1'b0, 16'h0000},
              2, 16'hBEEF, 1'b1, 1'b1, 1'b0, 1'b0, e);
        ack_at(e, 1, 16'hBEEF);
        wait_idle("mem_read");

        // locked IO write, ack at clk 5 coincides with expiry: ack wins
        issue(3'b011, 2'b10, 23'h000060, 16'h00A5, 1'b0, 1'b1,
              '{23'h000060, 2'b01, 1'b1, 1'b1, 1'b1, 16'h00A5},
              6, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, e);
        ack_at(e, 5, 16'h0000);
        wait_idle("io_write");

        issue(3'b110, 2'b01, 23'h000123, 16'h0000, 1'b1, 1'b1,
              '{23'h000123, 2'b10, 1'b0, 1'b0, 1'b0, 16'h0000},
              6, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0, e);
        ack_at(e, 5, 16'h1234);
        wait_idle("ack_at_limit");

        // no ack: forced termination
        issue(3'b110, 2'b00, 23'h001000, 16'h0000, 1'b1, 1'b1,
              '{23'h001000, 2'b11, 1'b0, 1'b0, 1'b0, 16'h0000},
              6, 16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b0, e);
        wait_idle("timeout");
        chk("late_ack_ignored_pre", cycle_active, 0);
        req_ack = 1'b1;
        @(negedge clk);
        req_ack = 1'b0;
        chk("late_ack_ignored", {cycle_active, ready_n}, 2'b01);

        // halt special cycle
        issue(3'b101, 2'b11, 23'h000002, 16'h0000, 1'b1, 1'b0,
              '{23'd0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000},
              2, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, e);
        chk("halt_special_pulse", special_cycle, 1);
        chk("halt_no_req", req_valid, 0);
        @(negedge clk);
        chk("halt_pulse_ends", special_cycle, 0);
        wait_idle("halt");

        // interrupt acknowledge returns zero data
        issue(3'b000, 2'b10, 23'h000002, 16'h0000, 1'b1, 1'b0,
              '{23'd0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000},
              2, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, e);
        chk("inta_special_pulse", special_cycle, 1);
        wait_idle("inta");

        // back-to-back reads: second ADS# sampled during RDY
        issue(3'b110, 2'b00, 23'h0ABCDE, 16'h0000, 1'b1, 1'b1,
              '{23'h0ABCDE, 2'b11, 1'b0, 1'b0, 1'b0, 16'h0000},
              2, 16'h5A5A, 1'b1, 1'b1, 1'b1, 1'b1, e);
        ack_at(e, 1, 16'h5A5A);
        issue(3'b110, 2'b00, 23'h0ABCE0, 16'h0000, 1'b1, 1'b1,
              '{23'h0ABCE0, 2'b11, 1'b0, 1'b0, 1'b0, 16'h0000},
              2, 16'hC3C3, 1'b1, 1'b1, 1'b1, 1'b1, e2);
        chk("b2b_req_no_gap", req_valid, 1);
        ack_at(e2, 1, 16'hC3C3);
        wait_idle("b2b");

        // reset in the middle of an outstanding request
        issue(3'b110, 2'b00, 23'h000400, 16'h0000, 1'b1, 1'b1,
              '{23'h000400, 2'b11, 1'b0, 1'b0, 1'b0, 16'h0000},
              0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, e);
        @(negedge clk);
        chk("midreq_valid_before_rst", req_valid, 1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midreq_rst_req_valid", req_valid, 0);
        chk("midreq_rst_idle", {cycle_active, ready_n}, 2'b01);
        chk("midreq_rst_sticky_clear", {halt_seen, timeout}, 2'b00);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("midreq_stays_idle", cycle_active, 0);

        chk("rdy_queue_drained", rdy_q.size(), 0);
        chk("req_queue_drained", req_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
